alu_core: RTL

- Synchronous ALU responder for the start/done operation protocol that the ALU bench drives and checks.
- Captures operands and opcode on an accepted start.
- Computes the operation: single-cycle for add/and/xor/no_op/rst_op, multi-cycle pipelined for mul.
- Pulses done for one cycle with result valid on the same edge.

---
 rtl/alu_core.sv | 117 +++++++++++
 1 files changed

// File: rtl/alu_core.sv
// Start/done ALU: done arrives 1 clock after accept (MUL_LAT clocks for mul); start is ignored while busy.
// Optional `ALU_SUB_EN adds opcode 101 = subtract; without it 101 behaves as no_op.
module alu_core #(
  parameter int WIDTH   = 8,
  parameter int MUL_LAT = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [2:0]         op,
  input  logic               start,
  output logic               done,
  output logic               busy,
  output logic [2*WIDTH-1:0] result
);

  localparam int W2   = 2 * WIDTH;
  localparam int NSTG = MUL_LAT - 1;

  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_RST = 3'b111;

  typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  a_q, b_q;
  logic [2:0]        op_q;
  logic [3:0]        cnt;
  logic [W2-1:0]     pipe [NSTG];
  logic [W2-1:0]     a_ext, b_ext, res_nxt;
  logic              accept, done_nxt;

  assign a_ext = {{WIDTH{1'b0}}, a_q};
  assign b_ext = {{WIDTH{1'b0}}, b_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    done_nxt  = 1'b0;
    res_nxt   = result;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = (op == OP_MUL) ? MUL : EXEC;
        end
      end
      EXEC: begin
        done_nxt  = 1'b1;
        state_nxt = IDLE;
        // Opcodes not listed (including 110) leave result untouched.
        case (op_q)
          OP_ADD:  res_nxt = a_ext + b_ext;
          OP_AND:  res_nxt = a_ext & b_ext;
          OP_XOR:  res_nxt = a_ext ^ b_ext;
          OP_RST:  res_nxt = '0;
`ifdef ALU_SUB_EN
          OP_SUB:  res_nxt = a_ext - b_ext;
`endif
          default: res_nxt = result;
        endcase
      end
      MUL: begin
        if (cnt == 4'(MUL_LAT - 1)) begin
          done_nxt  = 1'b1;
          res_nxt   = pipe[NSTG-1];
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      cnt    <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
      result <= '0;
      for (int i = 0; i < NSTG; i++) pipe[i] <= '0;
    end else begin
      done   <= done_nxt;
      result <= res_nxt;
      if (accept) begin
        a_q  <= A;
        b_q  <= B;
        op_q <= op;
        cnt  <= '0;
        busy <= 1'b1;
      end else if (done_nxt) begin
        busy <= 1'b0;
      end
      if (state == MUL) cnt <= cnt + 4'd1;
      // Operands are frozen while in MUL, so the pipe free-runs on them.
      pipe[0] <= a_ext * b_ext;
      for (int i = 1; i < NSTG; i++) pipe[i] <= pipe[i-1];
    end
  end

  // Opcode constant used only when the subtract option is built in.
  logic unused_sub;
  assign unused_sub = ^OP_SUB;

endmodule
